// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory front end with lane steering, load formatting and misalignment checks.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic        we_q, err_q, bad;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q, wdata_d, load_d;
  logic [3:0]  be_d;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  always_comb begin
    bad = (req_we ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                  : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110)))
        | ((req_funct3[1:0] == 2'b01) & req_addr[0])
        | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
    be_d = !req_we ? 4'b1111
         : (req_funct3[1:0] == 2'b00) ? 4'b0001 << req_addr[1:0]
         : (req_funct3[1:0] == 2'b01) ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = (req_funct3[1:0] == 2'b00) ? {4{req_wdata[7:0]}}
            : (req_funct3[1:0] == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
    byte_s = mem_rdata[{off_q, 3'b000} +: 8];
    half_s = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_d = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & byte_s[7]}}, byte_s}
           : (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & half_s[15]}}, half_s} : mem_rdata;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (bad ? RESP : REQ) : IDLE;
      REQ:     state_nx = mem_gnt ? (we_q ? RESP : WAIT) : REQ;
      WAIT:    state_nx = mem_rvalid ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Request fields are latched once at accept so the bus sees them stable until grant.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
    end else if (state == IDLE && req_valid) begin
      we_q      <= req_we;
      err_q     <= bad;
      f3_q      <= req_funct3;
      off_q     <= req_addr[1:0];
      rdata_q   <= 32'd0;
      mem_we    <= req_we;
      mem_addr  <= {req_addr[31:2], 2'b00};
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
    end else if (state == WAIT && mem_rvalid) begin
      rdata_q <= load_d;
    end
  assign req_ready = state == IDLE;
  assign mem_req   = state == REQ;
  assign rsp_valid = state == RESP;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand-written stall and reset sequences.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, mem_rdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
  } vec_t;
  vec_t vecs [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    accept(v.we, v.f3, v.addr, v.wdata);
    @(negedge clk);
    if (!v.err) begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(v.we));
      chk("mem_addr", mem_addr, v.exp_maddr);
      chk("mem_be", 32'(mem_be), 32'(v.exp_be));
      if (v.we) chk("mem_wdata", mem_wdata, v.exp_wdata);
      mem_gnt = 1'b1;
      @(posedge clk);
      #1 mem_gnt = 1'b0;
      if (!v.we) begin
        @(negedge clk);
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        @(posedge clk);
        #1 mem_rvalid = 1'b0; mem_rdata = 32'hX5A5_0000;
      end
      @(negedge clk);
    end else chk("err_no_mem_req", 32'(mem_req), 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
  endtask
  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h1002, 32'h0, 32'h1180_3344, 1'b0, 32'h1000, 4'hF, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 1'b0, 32'h2000, 4'hF, 32'h0, 32'h0000_BEEF};
    vecs[2]  = '{1'b1, 3'b000, 32'h3003, 32'hA5, 32'h0, 1'b0, 32'h3000, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[3]  = '{1'b0, 3'b010, 32'h4001, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 3'b011, 32'h4000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 3'b001, 32'h6000, 32'h0, 32'h1234_8001, 1'b0, 32'h6000, 4'hF, 32'h0, 32'hFFFF_8001};
    vecs[6]  = '{1'b0, 3'b100, 32'h7001, 32'h0, 32'h0000_F000, 1'b0, 32'h7000, 4'hF, 32'h0, 32'h0000_00F0};
    vecs[7]  = '{1'b1, 3'b001, 32'h8002, 32'h0000_CAFE, 32'h0, 1'b0, 32'h8000, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vecs[8]  = '{1'b0, 3'b010, 32'h9008, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h9008, 4'hF, 32'h0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 3'b100, 32'hA000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 3'b011, 32'hA000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h8001, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'b001, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 3'b000, 32'h0010, 32'h1234_5678, 32'h0, 1'b0, 32'h0010, 4'b0001, 32'h7878_7878, 32'h0};
    vecs[14] = '{1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_bus", {mem_we, 27'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) run_vec(vecs[i]);
    // grant stall on SW
    accept(1'b1, 3'b010, 32'h5004, 32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_req", 32'(mem_req), 32'd1);
      chk("stall_mem_addr", mem_addr, 32'h5004);
      chk("stall_mem_be", 32'(mem_be), 32'hF);
      chk("stall_mem_wdata", mem_wdata, 32'h0BAD_F00D);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    mem_gnt = 1'b1;
    @(posedge clk);
    #1 mem_gnt = 1'b0;
    begin
      int n_rsp = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (rsp_valid) n_rsp++;
      end
      chk("stall_one_rsp", 32'(n_rsp), 32'd1);
    end
    // stray grant while idle must not start anything
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("idle_gnt_ignored", {31'd0, mem_req | rsp_valid}, 32'd0);
    // reset mid-WAIT, then late rvalid
    accept(1'b0, 3'b010, 32'hC000, 32'h0);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(posedge clk);
    #1 mem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 mem_rvalid = 1'b0;
    begin
      int n_rsp = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (rsp_valid) n_rsp++;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
      end
      chk("late_rvalid_no_rsp", 32'(n_rsp), 32'd0);
    end
    chk("post_rst_rdata", rsp_rdata, 32'd0);
    chk("post_rst_mem_req", 32'(mem_req), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
